dice_roll_arbiter: RTL and testbench

- Shares one dice-roll engine between NUM_PLAYERS requesters using round-robin arbitration.
- Each granted request draws an 8-bit sample from an internal free-running LFSR. The sample is reduced modulo the requested die size by a sequential subtract loop, and the block returns a face value 1..sides tagged with the owner.
- Sits between player/game-control logic and the score datapath.

---
 rtl/dice_roll_arbiter.sv | 178 +++++++++++++++++
 tb/tb_dice_roll_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_arbiter.sv
// Round-robin shared dice-roll engine: LFSR sample reduced modulo die size by repeated subtraction.
// Optional statistics outputs (roll_count, last_crit) are enabled by defining DICE_ARB_STATS_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for any req; picks the next winner round-robin
// S_LOAD   | grant pulse; capture sample and die size for the winner
// S_REDUCE | subtract sides from rem until rem < sides
// S_DONE   | result_valid pulse, then back to idle
module dice_roll_arbiter #(
   parameter int          NUM_PLAYERS = 4,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_PLAYERS-1:0]         req,
   input  logic [2*NUM_PLAYERS-1:0]       die_sel,
   input  logic                           test_mode,
   input  logic [7:0]                     test_sample,
   output logic [NUM_PLAYERS-1:0]         grant,
   output logic                           busy,
   output logic [7:0]                     result,
`ifdef DICE_ARB_STATS_EN
   output logic [15:0]                    roll_count,
   output logic [0:0]                     last_crit,
`endif
   output logic                           result_valid,
   output logic [$clog2(NUM_PLAYERS)-1:0] result_owner
);

   localparam int               IDX_W    = $clog2(NUM_PLAYERS);
   localparam logic [15:0]      SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_REDUCE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [IDX_W-1:0] win_q, win_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [7:0]       rem_q, rem_d;
   logic [7:0]       sides_q, sides_d;
   logic [7:0]       result_q, result_d;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;
   logic [1:0]       die_code;
   int               idx;

   // Search upward from the player after the last winner, wrapping once around.
   always_comb begin
      pick       = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int i = 1; i <= NUM_PLAYERS; i++) begin
         idx      = (int'(last_q) + i) % NUM_PLAYERS;
         pick_idx = IDX_W'(idx);
         if (!pick_found && req[pick_idx]) begin
            pick       = pick_idx;
            pick_found = 1'b1;
         end
      end
   end

   assign die_code = die_sel[{win_q, 1'b0} +: 2];

   always_comb begin
      state_d  = state_q;
      lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
      win_d    = win_q;
      last_d   = last_q;
      owner_d  = owner_q;
      rem_d    = rem_q;
      sides_d  = sides_q;
      result_d = result_q;
      grant    = '0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               win_d   = pick;
               last_d  = pick;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            grant[win_q] = 1'b1;
            rem_d        = test_mode ? test_sample : lfsr_q[7:0];
            case (die_code)
               2'b00:   sides_d = 8'd4;
               2'b01:   sides_d = 8'd6;
               2'b10:   sides_d = 8'd8;
               default: sides_d = 8'd20;
            endcase
            state_d = S_REDUCE;
         end
         S_REDUCE: begin
            if (rem_q >= sides_q) begin
               rem_d = rem_q - sides_q;
            end else begin
               result_d = rem_q + 8'd1;
               owner_d  = win_q;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         lfsr_q   <= SEED_EFF;
         win_q    <= '0;
         last_q   <= LAST_IDX;
         owner_q  <= '0;
         rem_q    <= '0;
         sides_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         win_q    <= win_d;
         last_q   <= last_d;
         owner_q  <= owner_d;
         rem_q    <= rem_d;
         sides_q  <= sides_d;
         result_q <= result_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign result_valid = (state_q == S_DONE);
   assign result       = result_q;
   assign result_owner = owner_q;

`ifdef DICE_ARB_STATS_EN
   logic [15:0] roll_count_q, roll_count_d;
   logic        last_crit_q, last_crit_d;

   // A critical roll is the maximum face of the die in use.
   always_comb begin
      roll_count_d = roll_count_q;
      last_crit_d  = last_crit_q;
      if (state_q == S_DONE) begin
         if (roll_count_q != 16'hFFFF) begin
            roll_count_d = roll_count_q + 16'd1;
         end
         last_crit_d = (result_q == sides_q);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         roll_count_q <= '0;
         last_crit_q  <= 1'b0;
      end else begin
         roll_count_q <= roll_count_d;
         last_crit_q  <= last_crit_d;
      end
   end

   assign roll_count = roll_count_q;
   assign last_crit  = last_crit_q;
`endif

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Self-checking bench for dice_roll_arbiter: directed vector table, corner sequences and
// randomized rolls against a round-robin / modulo reference model (stats checked if DICE_ARB_STATS_EN).
module tb_dice_roll_arbiter;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req = 4'h0;
   logic [7:0] die_sel = 8'h00;
   logic       test_mode = 1'b0;
   logic [7:0] test_sample = 8'h00;
   logic [3:0] grant;
   logic       busy;
   logic [7:0] result;
   logic       result_valid;
   logic [1:0] result_owner;
`ifdef DICE_ARB_STATS_EN
   logic [15:0] roll_count;
   logic [0:0]  last_crit;
`endif

   int checks = 0;
   int failures = 0;
   int m_last = 3;
   logic [15:0] m_lfsr;

   dice_roll_arbiter #(.NUM_PLAYERS(4), .SEED(SEED)) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .die_sel      (die_sel),
      .test_mode    (test_mode),
      .test_sample  (test_sample),
      .grant        (grant),
      .busy         (busy),
      .result       (result),
`ifdef DICE_ARB_STATS_EN
      .roll_count   (roll_count),
      .last_crit    (last_crit),
`endif
      .result_valid (result_valid),
      .result_owner (result_owner)
   );

   always #5 clock = ~clock;

   // Reference LFSR: 16-bit Galois, mask B400, advancing every clock.
   always @(posedge clock) begin
      if (reset) m_lfsr <= (SEED == 16'h0000) ? 16'h0001 : SEED;
      else       m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] rq;
      logic [7:0] ds;
      logic [7:0] ts;
      logic [7:0] ds_after;
      int         own;
      int         res;
      int         lat;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic int code2sides(input logic [1:0] c);
      case (c)
         2'b00:   return 4;
         2'b01:   return 6;
         2'b10:   return 8;
         default: return 20;
      endcase
   endfunction

   function automatic int model_pick(input logic [3:0] rq);
      for (int i = 1; i <= 4; i++) begin
         if (rq[(m_last + i) % 4]) return (m_last + i) % 4;
      end
      return -1;
   endfunction

   // Starts in an IDLE cycle (cycle 0); returns in the IDLE cycle after DONE.
   task automatic do_roll(input logic [3:0] rq, input logic [7:0] ds, input logic tm,
                          input logic [7:0] ts, input logic hold, input logic [7:0] ds_after,
                          output logic [3:0] g, output int gcyc, output int gcnt,
                          output logic [7:0] samp, output int vcyc, output logic [7:0] res,
                          output logic [1:0] own, output int bcnt);
      int cyc;
      bit got_v;
      req = rq; die_sel = ds; test_mode = tm; test_sample = ts;
      g = '0; gcyc = -1; gcnt = 0; samp = '0; vcyc = -1; res = '0; own = '0; bcnt = 0;
      cyc = 0; got_v = 0;
      while (!got_v && cyc < 200) begin
         tick();
         cyc++;
         if (busy === 1'b1) bcnt++;
         if (grant !== 4'h0) begin
            gcnt++;
            if (gcyc < 0) begin
               g = grant; gcyc = cyc;
               samp = tm ? ts : m_lfsr[7:0];
               if (!hold) req = 4'h0;
            end
         end else if (gcyc >= 0 && cyc == gcyc + 1) begin
            die_sel = ds_after;
         end
         if (result_valid === 1'b1) begin
            got_v = 1; vcyc = cyc; res = result; own = result_owner;
         end
      end
      tick();
      check("valid_one_cycle", result_valid, 0);
      check("idle_after_done", busy, 0);
   endtask

   task automatic roll_chk(input string nm, input logic [3:0] rq, input logic [7:0] ds,
                           input logic tm, input logic [7:0] ts, input logic hold,
                           input logic [7:0] ds_after, input int e_own, input int e_res,
                           input int e_lat, input bit use_model);
      logic [3:0] g;
      logic [7:0] samp, res;
      logic [1:0] own;
      int gcyc, gcnt, vcyc, bcnt, sd;
      if (use_model) e_own = model_pick(rq);
      do_roll(rq, ds, tm, ts, hold, ds_after, g, gcyc, gcnt, samp, vcyc, res, own, bcnt);
      if (use_model) begin
         sd    = code2sides(ds[2*e_own +: 2]);
         e_res = int'(samp) % sd + 1;
         e_lat = 3 + int'(samp) / sd;
      end
      check({nm, "_grant_cycle"}, gcyc, 1);
      check({nm, "_grant"}, {28'd0, g}, 32'd1 << e_own);
      check({nm, "_grant_width"}, gcnt, 1);
      check({nm, "_latency"}, vcyc, e_lat);
      check({nm, "_result"}, {24'd0, res}, e_res);
      check({nm, "_owner"}, {30'd0, own}, e_own);
      check({nm, "_busy_cycles"}, bcnt, e_lat);
      m_last = e_own;
   endtask

   initial begin
      vecs[0]  = '{4'b0010, 8'h04, 8'd13,  8'h04, 1, 2,  5};
      vecs[1]  = '{4'b0100, 8'h00, 8'd255, 8'h00, 2, 4,  66};
      vecs[2]  = '{4'b1000, 8'hC5, 8'd0,   8'hC5, 3, 1,  3};
      vecs[3]  = '{4'b0001, 8'h03, 8'd19,  8'h03, 0, 20, 3};
      vecs[4]  = '{4'b0001, 8'h03, 8'd20,  8'h03, 0, 1,  4};
      vecs[5]  = '{4'b0010, 8'hFB, 8'd7,   8'hFB, 1, 8,  3};
      vecs[6]  = '{4'b1000, 8'h80, 8'd8,   8'h80, 3, 1,  4};
      vecs[7]  = '{4'b0100, 8'hDF, 8'd100, 8'hDF, 2, 5,  19};
      vecs[8]  = '{4'b0001, 8'h00, 8'd3,   8'h00, 0, 4,  3};
      vecs[9]  = '{4'b0010, 8'h04, 8'd13,  8'h00, 1, 2,  5};
      vecs[10] = '{4'b0010, 8'h00, 8'd4,   8'h00, 1, 1,  4};

      // Reset held with all players requesting.
      reset = 1'b1; req = 4'hF; test_mode = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_grant", {28'd0, grant}, 0);
         check("rst_busy", busy, 0);
         check("rst_result", {24'd0, result}, 0);
         check("rst_valid", result_valid, 0);
      end
      reset = 1'b0; m_last = 3;

      // Round robin with req held: owners rotate starting at player 0.
      for (int k = 0; k < 5; k++)
         roll_chk("rr_d20_19", 4'hF, 8'hFF, 1, 8'd19, 1, 8'hFF, k % 4, 20, 3, 0);
      for (int k = 0; k < 5; k++)
         roll_chk("rr_d20_0", 4'hF, 8'hFF, 1, 8'd0, 1, 8'hFF, (k + 1) % 4, 1, 3, 0);
      req = 4'h0;

      for (int v = 0; v < 11; v++)
         roll_chk($sformatf("vec%0d", v), vecs[v].rq, vecs[v].ds, 1, vecs[v].ts, 0,
                  vecs[v].ds_after, vecs[v].own, vecs[v].res, vecs[v].lat, 0);

      // Reset in the middle of a long reduction.
      req = 4'b0010; die_sel = 8'h00; test_mode = 1'b1; test_sample = 8'd200;
      for (int c = 1; c <= 10; c++) tick();
      check("midrst_busy_before", busy, 1);
      reset = 1'b1; m_last = 3;
      tick();
      reset = 1'b0; req = 4'h0;
      check("midrst_busy", busy, 0);
      check("midrst_result", {24'd0, result}, 0);
      check("midrst_owner", {30'd0, result_owner}, 0);
      check("midrst_valid", result_valid, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("midrst_no_valid", result_valid, 0);
         check("midrst_idle", busy, 0);
      end
      roll_chk("midrst_prio", 4'b1001, 8'h00, 1, 8'd5, 0, 8'h00, 0, 2, 4, 0);

      // Randomized rolls, LFSR or test sample, against the reference model.
      for (int n = 0; n < 40; n++) begin
         logic [3:0] rq;
         logic [7:0] ds, ts;
         logic       tm;
         rq = 4'($urandom_range(1, 15));
         ds = 8'($urandom);
         ts = 8'($urandom);
         tm = 1'($urandom_range(0, 1));
         roll_chk("rand", rq, ds, tm, ts, 0, ds, 0, 0, 0, 1);
      end

`ifdef DICE_ARB_STATS_EN
      reset = 1'b1; m_last = 3; req = 4'h0;
      tick(); tick();
      reset = 1'b0;
      check("stats_rst_count", {16'd0, roll_count}, 0);
      check("stats_rst_crit", {31'd0, last_crit}, 0);
      for (int n = 0; n < 5; n++)
         roll_chk("stats_d8_7", 4'b0001, 8'h02, 1, 8'd7, 0, 8'h02, 0, 8, 3, 0);
      check("stats_count5", {16'd0, roll_count}, 5);
      check("stats_crit1", {31'd0, last_crit}, 1);
      roll_chk("stats_d8_3", 4'b0001, 8'h02, 1, 8'd3, 0, 8'h02, 0, 4, 3, 0);
      check("stats_count6", {16'd0, roll_count}, 6);
      check("stats_crit0", {31'd0, last_crit}, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
